// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined CPU: opcodes, instruction field
// positions, the ID/EX register layout and per-opcode decode lookups.
package cpu_pkg;

  localparam int CPU_DATA_W = 8;
  localparam int CPU_ADR_W  = 3;
  localparam int CPU_PC_W   = 8;
  localparam int IMM_W      = 6;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RS_HI  = 11;
  localparam int RS_LO  = 9;
  localparam int RT_HI  = 8;
  localparam int RT_LO  = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 3;
  localparam int IMM_HI = 5;
  localparam int IMM_LO = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_ADDI = 4'h4,
    OP_LW   = 4'h5,
    OP_SW   = 4'h6,
    OP_BEQ  = 4'h7,
    OP_J    = 4'h8,
    OP_NOP  = 4'hF
  } opcode_t;

  typedef struct packed {
    logic                  valid;
    opcode_t               op;
    logic [CPU_DATA_W-1:0] a;
    logic [CPU_DATA_W-1:0] b;
    logic [CPU_DATA_W-1:0] imm;
    logic [CPU_ADR_W-1:0]  dst;
    logic                  wr_en;
    logic                  is_load;
    logic [CPU_PC_W-1:0]   pc;
  } idex_t;

  function automatic logic op_defined(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_NOP: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
      OP_LW, OP_SW, OP_BEQ: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rt(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SW, OP_BEQ: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rt(input opcode_t op);
    case (op)
      OP_ADDI, OP_LW: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/operand_forward.sv
// Per-operand bypass: r0 reads as zero, otherwise EX/MEM (non-load) beats WB
// which beats the register-file read data.
module operand_forward #(
  parameter int DATA_W = 8,
  parameter int ADR_W  = 3
) (
  input  logic [ADR_W-1:0]  src,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              exm_wr_en,
  input  logic              exm_is_load,
  input  logic [ADR_W-1:0]  exm_wr_adr,
  input  logic [DATA_W-1:0] exm_wr_data,
  input  logic              wb_wr_en,
  input  logic [ADR_W-1:0]  wb_wr_adr,
  input  logic [DATA_W-1:0] wb_wr_data,
  output logic [DATA_W-1:0] data
);

  // Priority mux; a load in EX/MEM has no data yet, so it never forwards.
  always_comb begin
    data = rf_data;
    if (src == {ADR_W{1'b0}}) begin
      data = {DATA_W{1'b0}};
    end else if (exm_wr_en && !exm_is_load && (exm_wr_adr == src)) begin
      data = exm_wr_data;
    end else if (wb_wr_en && (wb_wr_adr == src)) begin
      data = wb_wr_data;
    end else begin
      data = rf_data;
    end
  end

endmodule

// File: rtl/decode_issue_stage.sv
// ID stage: decodes the IF/ID instruction, forwards operands, detects
// load-use hazards and owns the ID/EX pipeline register.
module decode_issue_stage
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 8,
  parameter int ADR_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [7:0]         in_pc,
  output logic [ADR_W-1:0]   rf_adr1,
  output logic [ADR_W-1:0]   rf_adr2,
  input  logic [DATA_W-1:0]  rf_read1,
  input  logic [DATA_W-1:0]  rf_read2,
  input  logic               exm_wr_en,
  input  logic               exm_is_load,
  input  logic [ADR_W-1:0]   exm_wr_adr,
  input  logic [DATA_W-1:0]  exm_wr_data,
  input  logic               wb_wr_en,
  input  logic [ADR_W-1:0]   wb_wr_adr,
  input  logic [DATA_W-1:0]  wb_wr_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_op,
  output logic [DATA_W-1:0]  out_a,
  output logic [DATA_W-1:0]  out_b,
  output logic [DATA_W-1:0]  out_imm,
  output logic [ADR_W-1:0]   out_dst,
  output logic               out_wr_en,
  output logic               out_is_load,
  output logic [7:0]         out_pc
);

  opcode_t            raw_op;
  opcode_t            dec_op;
  logic [ADR_W-1:0]   rs;
  logic [ADR_W-1:0]   rt;
  logic [ADR_W-1:0]   rd;
  logic [ADR_W-1:0]   dst;
  logic [DATA_W-1:0]  imm_ext;
  logic [DATA_W-1:0]  fwd_a;
  logic [DATA_W-1:0]  fwd_b;
  logic               hz_rs;
  logic               hz_rt;
  logic               stall;
  logic               advance;
  idex_t              idex;
  idex_t              idex_next;

  assign raw_op  = opcode_t'(in_instr[OP_HI:OP_LO]);
  assign rs      = in_instr[RS_HI:RS_LO];
  assign rt      = in_instr[RT_HI:RT_LO];
  assign rd      = in_instr[RD_HI:RD_LO];
  assign imm_ext = {{(DATA_W-IMM_W){in_instr[IMM_HI]}}, in_instr[IMM_HI:IMM_LO]};
  assign rf_adr1 = rs;
  assign rf_adr2 = rt;

  // Opcode legalisation and destination selection.
  always_comb begin
    dec_op = OP_NOP;
    dst    = {ADR_W{1'b0}};
    if (op_defined(raw_op)) begin
      dec_op = raw_op;
    end else begin
      dec_op = OP_NOP;
    end
    if (writes_rd(dec_op)) begin
      dst = rd;
    end else if (writes_rt(dec_op)) begin
      dst = rt;
    end else begin
      dst = {ADR_W{1'b0}};
    end
  end

  // A load still in ID/EX or EX/MEM cannot supply its result yet.
  always_comb begin
    hz_rs = 1'b0;
    hz_rt = 1'b0;
    if (uses_rs(dec_op) && (rs != {ADR_W{1'b0}})) begin
      hz_rs = (idex.valid && idex.is_load && (idex.dst == rs)) ||
              (exm_wr_en && exm_is_load && (exm_wr_adr == rs));
    end else begin
      hz_rs = 1'b0;
    end
    if (uses_rt(dec_op) && (rt != {ADR_W{1'b0}})) begin
      hz_rt = (idex.valid && idex.is_load && (idex.dst == rt)) ||
              (exm_wr_en && exm_is_load && (exm_wr_adr == rt));
    end else begin
      hz_rt = 1'b0;
    end
  end

  assign stall    = in_valid && (hz_rs || hz_rt);
  assign advance  = !idex.valid || out_ready;
  assign in_ready = flush || (advance && !stall);

  operand_forward #(.DATA_W(DATA_W), .ADR_W(ADR_W)) u_fwd_a (
    .src         (rs),
    .rf_data     (rf_read1),
    .exm_wr_en   (exm_wr_en),
    .exm_is_load (exm_is_load),
    .exm_wr_adr  (exm_wr_adr),
    .exm_wr_data (exm_wr_data),
    .wb_wr_en    (wb_wr_en),
    .wb_wr_adr   (wb_wr_adr),
    .wb_wr_data  (wb_wr_data),
    .data        (fwd_a)
  );

  operand_forward #(.DATA_W(DATA_W), .ADR_W(ADR_W)) u_fwd_b (
    .src         (rt),
    .rf_data     (rf_read2),
    .exm_wr_en   (exm_wr_en),
    .exm_is_load (exm_is_load),
    .exm_wr_adr  (exm_wr_adr),
    .exm_wr_data (exm_wr_data),
    .wb_wr_en    (wb_wr_en),
    .wb_wr_adr   (wb_wr_adr),
    .wb_wr_data  (wb_wr_data),
    .data        (fwd_b)
  );

  // Next ID/EX contents when the instruction issues.
  always_comb begin
    idex_next         = '0;
    idex_next.valid   = in_valid;
    idex_next.op      = dec_op;
    idex_next.a       = fwd_a;
    idex_next.b       = fwd_b;
    idex_next.imm     = imm_ext;
    idex_next.dst     = dst;
    idex_next.wr_en   = (writes_rd(dec_op) || writes_rt(dec_op)) && (dst != {ADR_W{1'b0}});
    idex_next.is_load = (dec_op == OP_LW);
    idex_next.pc      = in_pc;
  end

  // ID/EX register; flush kills it even while EX is back-pressuring.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idex <= '0;
    end else if (flush) begin
      idex.valid <= 1'b0;
    end else if (advance) begin
      if (stall) begin
        idex.valid <= 1'b0;
      end else begin
        idex <= idex_next;
      end
    end
  end

  assign out_valid   = idex.valid;
  assign out_op      = idex.op;
  assign out_a       = idex.a;
  assign out_b       = idex.b;
  assign out_imm     = idex.imm;
  assign out_dst     = idex.dst;
  assign out_wr_en   = idex.wr_en;
  assign out_is_load = idex.is_load;
  assign out_pc      = idex.pc;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: a table of single-cycle issue vectors
// plus hand-written sequences for reset, load-use, back-pressure and flush.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [7:0]  in_pc;
  logic [2:0]  rf_adr1, rf_adr2;
  logic [7:0]  rf_read1, rf_read2;
  logic        exm_wr_en, exm_is_load;
  logic [2:0]  exm_wr_adr;
  logic [7:0]  exm_wr_data;
  logic        wb_wr_en;
  logic [2:0]  wb_wr_adr;
  logic [7:0]  wb_wr_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [3:0]  out_op;
  logic [7:0]  out_a, out_b, out_imm, out_pc;
  logic [2:0]  out_dst;
  logic        out_wr_en, out_is_load;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  rf1, rf2;
    logic        exm_en, exm_ld;
    logic [2:0]  exm_adr;
    logic [7:0]  exm_data;
    logic        wb_en;
    logic [2:0]  wb_adr;
    logic [7:0]  wb_data;
    logic        e_ready;
    logic [3:0]  e_op;
    logic [7:0]  e_a, e_b, e_imm;
    logic [2:0]  e_dst;
    logic        e_wr, e_ld;
  } vec_t;

  vec_t vecs[10];

  decode_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_adr1(rf_adr1), .rf_adr2(rf_adr2),
    .rf_read1(rf_read1), .rf_read2(rf_read2), .exm_wr_en(exm_wr_en),
    .exm_is_load(exm_is_load), .exm_wr_adr(exm_wr_adr), .exm_wr_data(exm_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_adr(wb_wr_adr), .wb_wr_data(wb_wr_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_dst(out_dst),
    .out_wr_en(out_wr_en), .out_is_load(out_is_load), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    exm_wr_en = 1'b0; exm_is_load = 1'b0; exm_wr_adr = 3'd0; exm_wr_data = 8'h00;
    wb_wr_en = 1'b0; wb_wr_adr = 3'd0; wb_wr_data = 8'h00;
  endtask

  initial begin
    // instr, rf1, rf2, exm en/ld/adr/data, wb en/adr/data, expected ready, op, a, b, imm, dst, wr, ld
    vecs[0] = '{16'h0298, 8'h05, 8'h07, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00,
                1'b1, 4'h0, 8'h05, 8'h07, 8'h18, 3'd3, 1'b1, 1'b0};
    vecs[1] = '{16'h02A8, 8'h33, 8'h44, 1'b1, 1'b0, 3'd1, 8'h20, 1'b1, 3'd1, 8'h10,
                1'b1, 4'h0, 8'h20, 8'h44, 8'hE8, 3'd5, 1'b1, 1'b0};
    vecs[2] = '{16'h02A8, 8'h33, 8'h44, 1'b0, 1'b0, 3'd1, 8'h20, 1'b1, 3'd1, 8'h10,
                1'b1, 4'h0, 8'h10, 8'h44, 8'hE8, 3'd5, 1'b1, 1'b0};
    vecs[3] = '{16'h0298, 8'h01, 8'h99, 1'b1, 1'b0, 3'd3, 8'h66, 1'b1, 3'd2, 8'h55,
                1'b1, 4'h0, 8'h01, 8'h55, 8'h18, 3'd3, 1'b1, 1'b0};
    vecs[4] = '{16'h12B0, 8'h09, 8'h03, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00,
                1'b1, 4'h1, 8'h09, 8'h03, 8'hF0, 3'd6, 1'b1, 1'b0};
    vecs[5] = '{16'h0240, 8'h0A, 8'h0A, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00,
                1'b1, 4'h0, 8'h0A, 8'h0A, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[6] = '{16'h413D, 8'h12, 8'h34, 1'b1, 1'b0, 3'd0, 8'h77, 1'b1, 3'd0, 8'h88,
                1'b1, 4'h4, 8'h00, 8'h34, 8'hFD, 3'd4, 1'b1, 1'b0};
    vecs[7] = '{16'h0008, 8'h12, 8'h34, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00,
                1'b1, 4'h0, 8'h00, 8'h00, 8'h08, 3'd1, 1'b1, 1'b0};
    vecs[8] = '{16'hA000, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00,
                1'b1, 4'hF, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[9] = '{16'h5284, 8'h40, 8'h22, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00,
                1'b1, 4'h5, 8'h40, 8'h22, 8'h04, 3'd2, 1'b1, 1'b1};

    // Reset held two cycles with a valid instruction presented.
    rst = 1'b0; in_valid = 1'b1; in_instr = 16'h0298; in_pc = 8'h01;
    rf_read1 = 8'h05; rf_read2 = 8'h07; out_ready = 1'b1; flush = 1'b0;
    clear_fwd();
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_op", out_op, 0);
    chk("rst_a", out_a, 0);
    chk("rst_b", out_b, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_dst", out_dst, 0);
    chk("rst_wr", out_wr_en, 0);
    chk("rst_ld", out_is_load, 0);
    chk("rst_pc", out_pc, 0);
    rst = 1'b1;
    tick();
    chk("rel_valid", out_valid, 1);
    chk("rel_a", out_a, 8'h05);
    chk("rel_pc", out_pc, 8'h01);

    // Table of independent issue vectors, EX always ready.
    for (int i = 0; i < 10; i++) begin
      in_instr = vecs[i].instr; in_pc = 8'h10 + 8'(i);
      rf_read1 = vecs[i].rf1; rf_read2 = vecs[i].rf2;
      exm_wr_en = vecs[i].exm_en; exm_is_load = vecs[i].exm_ld;
      exm_wr_adr = vecs[i].exm_adr; exm_wr_data = vecs[i].exm_data;
      wb_wr_en = vecs[i].wb_en; wb_wr_adr = vecs[i].wb_adr; wb_wr_data = vecs[i].wb_data;
      #1;
      chk($sformatf("v%0d_adr1", i), rf_adr1, vecs[i].instr[11:9]);
      chk($sformatf("v%0d_adr2", i), rf_adr2, vecs[i].instr[8:6]);
      chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ready);
      tick();
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_op", i), out_op, vecs[i].e_op);
      chk($sformatf("v%0d_a", i), out_a, vecs[i].e_a);
      chk($sformatf("v%0d_b", i), out_b, vecs[i].e_b);
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].e_imm);
      chk($sformatf("v%0d_dst", i), out_dst, vecs[i].e_dst);
      chk($sformatf("v%0d_wr", i), out_wr_en, vecs[i].e_wr);
      chk($sformatf("v%0d_ld", i), out_is_load, vecs[i].e_ld);
      chk($sformatf("v%0d_pc", i), out_pc, 8'h10 + 8'(i));
    end

    // Load-use: LW r2 now in ID/EX, ADD r4,r2,r1 waits two cycles.
    clear_fwd();
    in_instr = 16'h0460; in_pc = 8'h30; rf_read1 = 8'h11; rf_read2 = 8'h0B;
    #1;
    chk("lu_stall_idex", in_ready, 0);
    tick();
    chk("lu_bubble1", out_valid, 0);
    exm_wr_en = 1'b1; exm_is_load = 1'b1; exm_wr_adr = 3'd2; exm_wr_data = 8'hEE;
    #1;
    chk("lu_stall_exm", in_ready, 0);
    tick();
    chk("lu_bubble2", out_valid, 0);
    clear_fwd();
    wb_wr_en = 1'b1; wb_wr_adr = 3'd2; wb_wr_data = 8'h5A;
    #1;
    chk("lu_go", in_ready, 1);
    tick();
    chk("lu_valid", out_valid, 1);
    chk("lu_a", out_a, 8'h5A);
    chk("lu_b", out_b, 8'h0B);
    chk("lu_dst", out_dst, 4);
    chk("lu_pc", out_pc, 8'h30);

    // Back-pressure for three cycles, then flush.
    clear_fwd();
    out_ready = 1'b0; in_instr = 16'h12B0; in_pc = 8'h40;
    rf_read1 = 8'h77; rf_read2 = 8'h66;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c), in_ready, 0);
      tick();
      chk($sformatf("bp%0d_valid", c), out_valid, 1);
      chk($sformatf("bp%0d_op", c), out_op, 0);
      chk($sformatf("bp%0d_a", c), out_a, 8'h5A);
      chk($sformatf("bp%0d_pc", c), out_pc, 8'h30);
    end
    flush = 1'b1;
    #1;
    chk("fl_in_ready", in_ready, 1);
    tick();
    chk("fl_valid", out_valid, 0);

    // Flush with an empty ID/EX drops the presented instruction.
    tick();
    chk("fl2_valid", out_valid, 0);
    flush = 1'b0;

    // Empty ID/EX accepts even while EX is not ready.
    #1;
    chk("empty_in_ready", in_ready, 1);
    tick();
    chk("empty_load_valid", out_valid, 1);
    chk("empty_load_op", out_op, 1);
    chk("empty_load_a", out_a, 8'h77);
    chk("empty_load_pc", out_pc, 8'h40);

    // Idle input with EX ready drains to invalid.
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("drain_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
